// File: rtl/recognition_reporter.sv
// recognition_reporter: formats each recognition result as an ASCII line and streams it to a UART TX
module recognition_reporter #(
    parameter int SPEAKER_NUMBER = 4,
    parameter int DROP_CNT_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [2:0]                recognition_result,
    input  logic                      recognition_result_flag,
    input  logic                      tx_ready,
    output logic [7:0]                tx_data,
    output logic                      tx_valid,
    output logic                      busy,
    output logic [2:0]                last_result,
    output logic [DROP_CNT_WIDTH-1:0] drop_cnt
);
    typedef enum logic {IDLE, SEND} state_t;
    state_t r_state, w_next;
    logic [2:0] r_line, r_slot, r_idx, r_last;
    logic r_slot_full;
    logic [DROP_CNT_WIDTH-1:0] r_drop;
    logic w_xfer, w_end, w_open, w_load, w_to_line, w_store, w_drop;
    logic [7:0] w_digit, w_byte;
    assign w_xfer    = (r_state == SEND) & tx_ready;
    assign w_end     = w_xfer & (r_idx == 3'd6);
    // line register is free to take a new result: idle, or the final LF is leaving now
    assign w_open    = (r_state == IDLE) | w_end;
    assign w_load    = w_open & (r_slot_full | recognition_result_flag);
    assign w_to_line = w_open & ~r_slot_full & recognition_result_flag;
    // a slot being drained into the line this cycle can be refilled at the same time
    assign w_store   = recognition_result_flag & ~w_to_line & (~r_slot_full | w_open);
    assign w_drop    = recognition_result_flag & r_slot_full & ~w_open;
    assign w_digit   = (int'({29'b0, r_line}) < SPEAKER_NUMBER) ? 8'h30 + {5'b0, r_line} : 8'h3F;
    assign tx_valid    = r_state == SEND;
    assign tx_data     = tx_valid ? w_byte : 8'h00;
    assign busy        = tx_valid | r_slot_full;
    assign last_result = r_last;
    assign drop_cnt    = r_drop;
    // state register
    always_ff @(posedge clk) begin
        r_state <= rst ? IDLE : w_next;
    end
    // next state: start or chain a line whenever one is loaded, otherwise fall idle after LF
    always_comb begin
        w_next = r_state;
        w_next = w_load ? SEND : (w_end ? IDLE : r_state);
    end
    // byte selection for the current position in the line
    always_comb begin
        w_byte = 8'h00;
        case (r_idx)
            3'd0: w_byte = 8'h53;
            3'd1: w_byte = 8'h50;
            3'd2: w_byte = 8'h4B;
            3'd3: w_byte = 8'h3A;
            3'd4: w_byte = w_digit;
            3'd5: w_byte = 8'h0D;
            3'd6: w_byte = 8'h0A;
            default: w_byte = 8'h00;
        endcase
    end
    // line, pending slot, byte index and statistics
    always_ff @(posedge clk) begin
        if (rst) begin
            r_line      <= 3'b111;
            r_slot      <= 3'b000;
            r_slot_full <= 1'b0;
            r_idx       <= 3'd0;
            r_last      <= 3'b111;
            r_drop      <= '0;
        end else begin
            r_idx       <= w_open ? 3'd0 : (w_xfer ? r_idx + 3'd1 : r_idx);
            r_slot_full <= w_store | (r_slot_full & ~w_open);
            if (w_load)
                r_line <= r_slot_full ? r_slot : recognition_result;
            if (w_store)
                r_slot <= recognition_result;
            if (recognition_result_flag)
                r_last <= recognition_result;
            if (w_drop && r_drop != '1)
                r_drop <= r_drop + 1'b1;
        end
    end
endmodule

// File: tb/tb_recognition_reporter.sv
// tb_recognition_reporter: scoreboard bench for recognition_reporter
module tb_recognition_reporter;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] recognition_result = 3'b000;
    logic       recognition_result_flag = 1'b0;
    logic       tx_ready = 1'b1;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       busy;
    logic [2:0] last_result;
    logic [7:0] drop_cnt;
    int n_cmp = 0;
    int n_err = 0;
    logic [7:0] q[$];

    recognition_reporter #(.SPEAKER_NUMBER(4), .DROP_CNT_WIDTH(8)) dut (
        .clk(clk), .rst(rst),
        .recognition_result(recognition_result),
        .recognition_result_flag(recognition_result_flag),
        .tx_ready(tx_ready), .tx_data(tx_data), .tx_valid(tx_valid),
        .busy(busy), .last_result(last_result), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_line(input logic [2:0] r);
        q.push_back(8'h53);
        q.push_back(8'h50);
        q.push_back(8'h4B);
        q.push_back(8'h3A);
        q.push_back(r < 3'd4 ? 8'h30 + {5'b0, r} : 8'h3F);
        q.push_back(8'h0D);
        q.push_back(8'h0A);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [2:0] r, input bit expect_line);
        recognition_result = r;
        recognition_result_flag = 1'b1;
        if (expect_line) push_line(r);
        cyc(1);
        recognition_result_flag = 1'b0;
    endtask

    task automatic drain(input bit rnd);
        int n = 0;
        while ((q.size() != 0 || busy) && n < 400) begin
            if (rnd) tx_ready = 1'($urandom_range(0, 1));
            cyc(1);
            n++;
        end
        tx_ready = 1'b1;
        chk("drain_left", q.size(), 0);
        chk("idle_valid", tx_valid, 1'b0);
    endtask

    // every valid byte must match the scoreboard head; it is consumed only on a transfer
    always @(negedge clk) begin
        if (!rst && tx_valid) begin
            if (q.size() == 0) chk("spurious_valid", 1, 0);
            else begin
                chk("tx_byte", tx_data, q[0]);
                if (tx_ready) void'(q.pop_front());
            end
        end
    end

    initial begin
        cyc(2);
        chk("rst_valid", tx_valid, 1'b0);
        chk("rst_data", tx_data, 8'h00);
        chk("rst_busy", busy, 1'b0);
        chk("rst_last", last_result, 3'b111);
        chk("rst_drop", drop_cnt, 8'h00);
        rst = 1'b0;
        cyc(1);
        pulse(3'd2, 1'b1);
        chk("lat_valid", tx_valid, 1'b1);
        chk("lat_data", tx_data, 8'h53);
        drain(1'b0);
        chk("last_2", last_result, 3'd2);
        pulse(3'd7, 1'b1);
        drain(1'b0);
        pulse(3'd5, 1'b1);
        drain(1'b0);
        chk("last_5", last_result, 3'd5);
        pulse(3'd1, 1'b1);
        drain(1'b1);
        tx_ready = 1'b0;
        pulse(3'd0, 1'b1);
        cyc(1);
        pulse(3'd1, 1'b1);
        chk("pend_busy", busy, 1'b1);
        cyc(1);
        pulse(3'd3, 1'b0);
        chk("ovr_drop", drop_cnt, 8'd1);
        chk("ovr_last", last_result, 3'd3);
        chk("stall_data", tx_data, 8'h53);
        tx_ready = 1'b1;
        drain(1'b0);
        chk("ovr_drop_end", drop_cnt, 8'd1);
        pulse(3'd2, 1'b1);
        cyc(2);
        pulse(3'd3, 1'b1);
        cyc(3);
        pulse(3'd1, 1'b1);
        chk("b2b_valid", tx_valid, 1'b1);
        chk("b2b_data", tx_data, 8'h53);
        chk("b2b_busy", busy, 1'b1);
        chk("b2b_drop", drop_cnt, 8'd1);
        drain(1'b0);
        chk("b2b_drop_end", drop_cnt, 8'd1);
        chk("b2b_last", last_result, 3'd1);
        pulse(3'd6, 1'b1);
        cyc(4);
        rst = 1'b1;
        cyc(1);
        q.delete();
        rst = 1'b0;
        chk("mid_rst_valid", tx_valid, 1'b0);
        chk("mid_rst_drop", drop_cnt, 8'd0);
        chk("mid_rst_last", last_result, 3'b111);
        chk("mid_rst_busy", busy, 1'b0);
        cyc(1);
        chk("mid_rst_quiet", tx_valid, 1'b0);
        pulse(3'd3, 1'b1);
        chk("fresh_data", tx_data, 8'h53);
        drain(1'b0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
